// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: load/store funct3 encodings and the store-buffer depth default.
package riscv_pkg;

  localparam int STORE_BUF_DEPTH = 4;

  // Store funct3 encodings.
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  // Load funct3 encodings.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == SB) || (f3 == SH) || (f3 == SW);
  endfunction

endpackage

// File: rtl/store_buf_match.sv
// Youngest-match search over the live store-buffer entries for one load address.
module store_buf_match
  import riscv_pkg::*;
#(
  parameter int DEPTH      = STORE_BUF_DEPTH,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic [DEPTH-1:0][2:0]            ent_funct3_i,
  input  logic [DEPTH-1:0][ADDR_WIDTH-3:0] ent_waddr_i,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data_i,
  input  logic [PTR_W-1:0]                 head_i,
  input  logic [CNT_W-1:0]                 count_i,
  input  logic [2:0]                       ld_funct3_i,
  input  logic [ADDR_WIDTH-1:0]            ld_addr_i,
  output logic                             hit_o,
  output logic                             fwd_ok_o,
  output logic [DATA_WIDTH-1:0]            fwd_data_o
);

  logic ld_word_aligned;

  assign ld_word_aligned = (ld_addr_i[1:0] == 2'b00);

  // Walk oldest to youngest; a later match overwrites an earlier one, so the
  // youngest matching store wins.
  always_comb begin : scan
    logic [PTR_W-1:0] idx;
    idx        = '0;
    hit_o      = 1'b0;
    fwd_ok_o   = 1'b0;
    fwd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if ((CNT_W'(i) < count_i) && (ent_waddr_i[idx] == ld_addr_i[ADDR_WIDTH-1:2])) begin
        hit_o      = 1'b1;
        fwd_ok_o   = (ent_funct3_i[idx] == SW) && (ld_funct3_i == LW) && ld_word_aligned;
        fwd_data_o = ent_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between MEM stage and data memory, with load forwarding/stall.
module store_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH      = STORE_BUF_DEPTH,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  input  logic [2:0]            st_funct3,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_ready,
  input  logic                  ld_valid,
  input  logic [2:0]            ld_funct3,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_stall,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][2:0]            funct3_q;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [DEPTH-1:0][ADDR_WIDTH-3:0] ent_waddr;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                  push;
  logic                  drain;
  logic                  hit;
  logic                  fwd_ok;
  logic [DATA_WIDTH-1:0] fwd_data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_waddr[i] = addr_q[i][ADDR_WIDTH-1:2];
    end
  end

  store_buf_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_match (
    .ent_funct3_i (funct3_q),
    .ent_waddr_i  (ent_waddr),
    .ent_data_i   (data_q),
    .head_i       (head_q),
    .count_i      (count_q),
    .ld_funct3_i  (ld_funct3),
    .ld_addr_i    (ld_addr),
    .hit_o        (hit),
    .fwd_ok_o     (fwd_ok),
    .fwd_data_o   (fwd_data)
  );

  assign st_ready = (count_q < CNT_W'(DEPTH));
  assign ld_stall = ld_valid && hit && !fwd_ok;

  // The memory port goes to the load unless the load is absent or stalled.
  // A reset cycle neither pushes nor writes memory.
  assign push  = st_valid && st_ready && is_store_f3(st_funct3) && !reset;
  assign drain = (count_q != '0) && (!ld_valid || ld_stall) && !reset;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and infers a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + PTR_W'(1);
    if (push)  tail_d = tail_q + PTR_W'(1);
    unique case ({push, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: registers use <= so every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q alone decides which
  // slots are live, so clearing count_q invalidates every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      funct3_q[tail_q] <= st_funct3;
      addr_q[tail_q]   <= st_addr;
      data_q[tail_q]   <= st_data;
    end
  end

  always_comb begin
    mem_wr_en   = drain;
    mem_wr_data = data_q[head_q];
    mem_funct3  = drain ? funct3_q[head_q] : ld_funct3;
    mem_addr    = drain ? addr_q[head_q]   : ld_addr;
    ld_data     = (ld_valid && fwd_ok) ? fwd_data : mem_rd_data;
  end

  occupancy_bounded: assert property (@(posedge clk) disable iff (reset)
    count_q <= CNT_W'(DEPTH));

  no_drain_when_empty: assert property (@(posedge clk) disable iff (reset)
    !(drain && count_q == '0));

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model and a byte-lane data memory.
module tb_store_buffer;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [2:0]    st_funct3;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [2:0]    ld_funct3;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_stall;
  logic          mem_wr_en;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_funct3   (st_funct3),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_funct3   (ld_funct3),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_stall    (ld_stall),
    .mem_wr_en   (mem_wr_en),
    .mem_funct3  (mem_funct3),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Word after a store of type f3 lands on it.
  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    w = old;
    case (f3)
      SB:      w[a[1:0]*8 +: 8]  = d[7:0];
      SH:      w[a[1]*16 +: 16]  = d[15:0];
      default: w = d;
    endcase
    return w;
  endfunction

  // Load result of type f3 taken from a memory word.
  function automatic logic [31:0] load_word(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [31:0] a);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = w >> (a[1:0] * 8);
    hsh = w >> (a[1] * 16);
    case (f3)
      LB:      return {{24{bsh[7]}}, bsh[7:0]};
      LBU:     return {24'h0, bsh[7:0]};
      LH:      return {{16{hsh[15]}}, hsh[15:0]};
      LHU:     return {16'h0, hsh[15:0]};
      default: return w;
    endcase
  endfunction

  // Data memory attached to the DUT: 64 words, combinational read.
  logic [31:0] dmem [64];

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = 32'hA500_0000 | i;
    forever begin
      @(posedge clk);
      if (mem_wr_en) dmem[mem_addr[7:2]] = merge_word(dmem[mem_addr[7:2]], mem_funct3, mem_addr, mem_wr_data);
    end
  end

  assign mem_rd_data = load_word(dmem[mem_addr[7:2]], mem_funct3, mem_addr);

  // Reference model: a FIFO of pending stores and the memory image they eventually build.
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t         sq[$];
  logic [31:0] rmem [64];

  initial begin : model
    bit          live;
    bit          e_drain, e_push, e_stall, hit, fwd;
    logic [31:0] fdata;
    live = 1'b0;
    for (int i = 0; i < 64; i++) rmem[i] = 32'hA500_0000 | i;
    forever begin
      @(negedge clk);
      e_drain = 1'b0;
      e_push  = 1'b0;
      if (live && !reset) begin
        hit   = 1'b0;
        fwd   = 1'b0;
        fdata = '0;
        if (ld_valid) begin
          for (int i = sq.size() - 1; i >= 0; i--) begin
            if (sq[i].a[31:2] == ld_addr[31:2]) begin
              hit   = 1'b1;
              fwd   = (sq[i].f3 == SW) && (ld_funct3 == LW) && (ld_addr[1:0] == 2'b00);
              fdata = sq[i].d;
              break;
            end
          end
        end
        e_stall = hit && !fwd;
        e_drain = (sq.size() > 0) && (!ld_valid || e_stall);
        e_push  = st_valid && (sq.size() < DEPTH) && is_store_f3(st_funct3);
        check("m_st_ready", st_ready, (sq.size() < DEPTH) ? 1 : 0);
        check("m_ld_stall", ld_stall, e_stall);
        check("m_wr_en", mem_wr_en, e_drain);
        if (e_drain) begin
          check("m_drain_addr", mem_addr, sq[0].a);
          check("m_drain_f3", mem_funct3, sq[0].f3);
          check("m_drain_data", mem_wr_data, sq[0].d);
        end else if (ld_valid) begin
          check("m_ld_addr", mem_addr, ld_addr);
          check("m_ld_f3", mem_funct3, ld_funct3);
        end
        if (ld_valid && !e_stall)
          check("m_ld_data", ld_data, fwd ? fdata : load_word(rmem[ld_addr[7:2]], ld_funct3, ld_addr));
      end else if (live) begin
        check("m_rst_wr_en", mem_wr_en, 0);
      end
      @(posedge clk);
      if (reset) begin
        sq.delete();
        live = 1'b1;
      end else if (live) begin
        if (e_drain) begin
          rmem[sq[0].a[7:2]] = merge_word(rmem[sq[0].a[7:2]], sq[0].f3, sq[0].a, sq[0].d);
          void'(sq.pop_front());
        end
        if (e_push) sq.push_back('{f3: st_funct3, a: st_addr, d: st_data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = v;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  task automatic ld(input logic v, input logic [2:0] f3, input logic [31:0] a);
    ld_valid  = v;
    ld_funct3 = f3;
    ld_addr   = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    st(0, SW, 0, 0);
    ld(0, LW, 0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_st_ready", st_ready, 1);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_ld_stall", ld_stall, 0);
    check("rst_ld_data", ld_data, 32'hA500_0000);
    step();

    // Single sw drains on the first idle cycle after its push.
    st(1, SW, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    check("s1_no_bypass", mem_wr_en, 0);
    step();
    st(0, SW, 0, 0);
    @(negedge clk);
    check("s1_wr_en", mem_wr_en, 1);
    check("s1_addr", mem_addr, 32'h10);
    check("s1_data", mem_wr_data, 32'hDEAD_BEEF);
    check("s1_count1", dut.count_q, 1);
    step();
    @(negedge clk);
    check("s1_count0", dut.count_q, 0);
    check("s1_model_empty", sq.size(), 0);
    check("s1_model_mem", rmem[4], 32'hDEAD_BEEF);
    check("s1_mem", dmem[4], 32'hDEAD_BEEF);
    step();

    // Fill while a non-matching load owns the memory port.
    ld(1, LW, 32'h80);
    for (int k = 0; k < 4; k++) begin
      st(1, SW, 32'h30 + 4 * k, 32'hB0 + k);
      @(negedge clk);
      check("s2_ready_fill", st_ready, 1);
      check("s2_no_drain", mem_wr_en, 0);
      step();
    end
    st(1, SW, 32'h40, 32'hB4);
    @(negedge clk);
    check("s2_full_ready", st_ready, 0);
    check("s2_full_wr_en", mem_wr_en, 0);
    check("s2_full_count", dut.count_q, 4);
    check("s2_ld_data", ld_data, 32'hA500_0020);
    step();
    @(negedge clk);
    check("s2_held_count", dut.count_q, 4);
    step();
    ld(0, LW, 0);
    @(negedge clk);
    check("s2_drain0_addr", mem_addr, 32'h30);
    check("s2_drain0_ready", st_ready, 0);
    step();
    @(negedge clk);
    check("s2_drain1_addr", mem_addr, 32'h34);
    check("s2_push5_ready", st_ready, 1);
    step();
    st(0, SW, 0, 0);
    repeat (3) step();
    @(negedge clk);
    check("s2_count0", dut.count_q, 0);
    check("s2_model_mem", rmem[16], 32'hB4);
    step();

    // sw then aligned lw: forward, memory not written.
    st(1, SW, 32'h20, 32'h1234_5678);
    @(negedge clk);
    step();
    st(0, SW, 0, 0);
    ld(1, LW, 32'h20);
    @(negedge clk);
    check("s3_stall", ld_stall, 0);
    check("s3_ld_data", ld_data, 32'h1234_5678);
    check("s3_wr_en", mem_wr_en, 0);
    check("s3_addr", mem_addr, 32'h20);
    step();
    ld(0, LW, 0);
    @(negedge clk);
    check("s3_drain_addr", mem_addr, 32'h20);
    step();

    // sw + sb to the same word: lw stalls until both drain, then reads merged word.
    ld(1, LW, 32'h80);
    st(1, SW, 32'h24, 32'h1111_1111);
    @(negedge clk);
    step();
    st(1, SB, 32'h25, 32'hAA);
    @(negedge clk);
    check("s4_hold", mem_wr_en, 0);
    step();
    st(0, SW, 0, 0);
    ld(1, LW, 32'h24);
    @(negedge clk);
    check("s4_stall0", ld_stall, 1);
    check("s4_drain0_addr", mem_addr, 32'h24);
    check("s4_drain0_f3", mem_funct3, SW);
    step();
    @(negedge clk);
    check("s4_stall1", ld_stall, 1);
    check("s4_drain1_addr", mem_addr, 32'h25);
    check("s4_drain1_f3", mem_funct3, SB);
    check("s4_drain1_data", mem_wr_data, 32'hAA);
    step();
    @(negedge clk);
    check("s4_stall_clear", ld_stall, 0);
    check("s4_ld_data", ld_data, 32'h1111_AA11);
    step();

    // Youngest match wins; illegal funct3 store is dropped; non-forwardable loads stall.
    ld(1, LW, 32'h80);
    st(1, SB, 32'h60, 32'h77);
    @(negedge clk);
    step();
    st(1, SW, 32'h60, 32'hCAFE_F00D);
    @(negedge clk);
    step();
    st(1, 3'b011, 32'h64, 32'h99);
    @(negedge clk);
    step();
    st(0, SW, 0, 0);
    ld(1, LW, 32'h60);
    @(negedge clk);
    check("s5_discard_count", dut.count_q, 2);
    check("s5_fwd_stall", ld_stall, 0);
    check("s5_fwd_data", ld_data, 32'hCAFE_F00D);
    step();
    ld(1, LH, 32'h60);
    @(negedge clk);
    check("s5_lh_stall", ld_stall, 1);
    check("s5_lh_drain_f3", mem_funct3, SB);
    step();
    ld(1, LW, 32'h62);
    @(negedge clk);
    check("s5_misalign_stall", ld_stall, 1);
    check("s5_misalign_f3", mem_funct3, SW);
    step();
    ld(1, LBU, 32'h63);
    @(negedge clk);
    check("s5_lbu", ld_data, 32'hCA);
    step();
    ld(1, LB, 32'h63);
    @(negedge clk);
    check("s5_lb", ld_data, 32'hFFFF_FFCA);
    step();

    // Push and drain together at count 2, tail wrapping past DEPTH-1.
    ld(1, LW, 32'h80);
    st(1, SW, 32'h50, 32'h50);
    @(negedge clk);
    step();
    st(1, SW, 32'h54, 32'h54);
    @(negedge clk);
    check("s6_tail_wrap", dut.tail_q, 0);
    step();
    ld(0, LW, 0);
    st(1, SW, 32'h58, 32'h58);
    @(negedge clk);
    check("s6_count_pre", dut.count_q, 2);
    check("s6_drain_a", mem_addr, 32'h50);
    step();
    st(1, SW, 32'h5C, 32'h5C);
    @(negedge clk);
    check("s6_count_mid", dut.count_q, 2);
    check("s6_drain_b", mem_addr, 32'h54);
    step();
    st(0, SW, 0, 0);
    @(negedge clk);
    check("s6_count_post", dut.count_q, 2);
    check("s6_head", dut.head_q, 1);
    check("s6_tail", dut.tail_q, 3);
    check("s6_drain_c", mem_addr, 32'h58);
    step();
    @(negedge clk);
    check("s6_drain_d", mem_addr, 32'h5C);
    step();

    // Reset with three buffered stores discards them.
    ld(1, LW, 32'h80);
    for (int k = 0; k < 3; k++) begin
      st(1, SW, 32'h90 + 4 * k, 32'h5500 + k);
      @(negedge clk);
      step();
    end
    reset = 1'b1;
    st(1, SW, 32'h9C, 32'h5503);
    ld(0, LW, 0);
    @(negedge clk);
    check("s7_rst_cycle_wr_en", mem_wr_en, 0);
    step();
    reset = 1'b0;
    st(0, SW, 0, 0);
    @(negedge clk);
    check("s7_count", dut.count_q, 0);
    check("s7_st_ready", st_ready, 1);
    check("s7_wr_en", mem_wr_en, 0);
    step();
    ld(1, LW, 32'h90);
    @(negedge clk);
    check("s7_old_90", ld_data, 32'hA500_0024);
    step();
    ld(1, LW, 32'h98);
    @(negedge clk);
    check("s7_old_98", ld_data, 32'hA500_0026);
    step();
    ld(1, LW, 32'h9C);
    @(negedge clk);
    check("s7_old_9c", ld_data, 32'hA500_0027);
    step();
    ld(0, LW, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL expose parameters, one per line:
- DEPTH, 4, number of store entries, power of two, at least 2.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width.
REQ-002 The block SHALL expose ports, one per line:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  MEM-stage store request.
- st_funct3  in  3  store type: 000 sb, 001 sh, 010 sw.
- st_addr  in  ADDR_WIDTH  store byte address.
- st_data  in  DATA_WIDTH  store data.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  MEM-stage load request.
- ld_funct3  in  3  load type: 000, 001, 010, 100, 101.
- ld_addr  in  ADDR_WIDTH  load byte address.
- ld_data  out  DATA_WIDTH  load result for the pipeline.
- ld_stall  out  1  load must hold in MEM this cycle.
- mem_wr_en  out  1  write enable to the data memory.
- mem_funct3  out  3  funct3 to the data memory.
- mem_addr  out  ADDR_WIDTH  address to the data memory (shared read/write port).
- mem_wr_data  out  DATA_WIDTH  write data to the data memory.
- mem_rd_data  in  DATA_WIDTH  combinational read data from the data memory.
REQ-003 The single clock SHALL be clk, and reset SHALL be synchronous and active-high on port reset.

Function
REQ-004 The buffer SHALL be a circular FIFO of DEPTH entries, each holding {funct3, addr, data}, with head, tail and count registers.
REQ-005 st_ready SHALL equal (count < DEPTH), computed combinationally.
REQ-006 A push SHALL occur at the clock edge when st_valid and st_ready are 1 and st_funct3 is 000, 001 or 010.
REQ-007 A store with any other st_funct3 SHALL be discarded and SHALL change no state.
REQ-008 A drain SHALL occur when count > 0 and (ld_valid == 0 or ld_stall == 1).
REQ-009 During a drain, mem_wr_en SHALL be 1 and mem_funct3, mem_addr and mem_wr_data SHALL carry the head entry; the entry is popped at that clock edge.
REQ-010 When no drain occurs, mem_wr_en SHALL be 0.
REQ-011 mem_addr SHALL equal ld_addr and mem_funct3 SHALL equal ld_funct3 when ld_valid is 1 and ld_stall is 0.
REQ-012 A pushed entry SHALL become drainable no earlier than the cycle after its push; there is no zero-cycle bypass to memory.
REQ-013 Simultaneous push and drain SHALL advance both head and tail and leave count unchanged.
REQ-014 A push when full SHALL be impossible, because st_ready gates it.
REQ-015 Pointers SHALL wrap modulo DEPTH.
REQ-016 A load SHALL match an entry when ld_addr[ADDR_WIDTH-1:2] equals the entry's addr[ADDR_WIDTH-1:2]. This is a conservative word-granular check.
REQ-017 When a load has no matching entry, ld_stall SHALL be 0 and ld_data SHALL equal mem_rd_data.
REQ-018 Forwarding: when the youngest matching entry has funct3 010, ld_funct3 is 010, and ld_addr[1:0] is 00, then ld_stall SHALL be 0, ld_data SHALL equal that entry's data, and memory SHALL not be read.
REQ-019 Any other match SHALL set ld_stall = 1, and draining SHALL proceed every cycle until no match remains.
REQ-020 ld_stall SHALL be 0 whenever ld_valid is 0.
REQ-021 Forwarding and stall logic SHALL be purely combinational, with a same-cycle response.

Reset
REQ-022 On reset = 1 at a clock edge, head, tail and count SHALL become 0 and all entries SHALL be invalidated.
REQ-023 A push or drain requested in a reset cycle SHALL be ignored.
REQ-024 Buffered stores SHALL be discarded when reset is asserted mid-operation.
REQ-025 After reset, outputs SHALL be: st_ready = 1, mem_wr_en = 0, ld_stall = 0, and ld_data = mem_rd_data.

Structure
REQ-026 The funct3 constants (SB, SH, SW, LB, LH, LW, LBU, LHU) and the DEPTH default SHALL live in the shared riscv_pkg package.
REQ-027 Youngest-match selection SHALL be one combinational sub-module, store_buf_match. It takes the entry vectors, head and count, and returns hit, fwd_ok and fwd_data.
REQ-028 The data memory SHALL remain a separate instance, driven only through the mem_* ports.

Verification
REQ-029 The bench SHALL cover these directed scenarios, one line each:
- sw 0xDEADBEEF to 0x10, no loads, one idle cycle -> mem_wr_en = 1, mem_addr = 0x10, mem_wr_data = 0xDEADBEEF, count returns to 0.
- 4 sw pushed back-to-back while ld_valid is held 1 at 0x80 -> st_ready = 0 after the 4th push, no drain occurs, 5th store is held.
- sw 0x12345678 to 0x20, then lw 0x20 -> ld_stall = 0, ld_data = 0x12345678, mem_addr = 0x20 not written that cycle.
- sw 0x11111111 to 0x24, then sb 0xAA to 0x25, then lw 0x24 -> ld_stall = 1 until both entries drain, then ld_data = 0x1111AA11 from memory.
- push and drain in the same cycle with count = 2 -> count stays 2 and pointers wrap correctly across DEPTH.
- reset asserted with count = 3 -> next cycle count = 0, st_ready = 1, mem_wr_en = 0, and a later lw of those addresses returns the old memory contents.
